// File: rtl/chicken_pkg.sv
// Shared constants for the game datapath: FSM state codes, card count and player limits.
package chicken_pkg;

    localparam logic [2:0] ST_TITLE   = 3'b000;
    localparam logic [2:0] ST_SELECT  = 3'b001;
    localparam logic [2:0] ST_SHUFFLE = 3'b010;
    localparam logic [2:0] ST_WAIT    = 3'b011;
    localparam logic [2:0] ST_EVAL    = 3'b100;
    localparam logic [2:0] ST_MISS    = 3'b101;
    localparam logic [2:0] ST_MOVE    = 3'b110;
    localparam logic [2:0] ST_WIN     = 3'b111;

    localparam int NUM_CARDS   = 8;
    localparam int MAX_PLAYERS = 4;
    localparam int POS_W       = 5;
    localparam int CNT_W       = 16;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with 16'hACE1 on reset.
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/game_datapath.sv
// Game datapath: board, player positions, turn order, card selection and per-state timers.
// Define SHUFFLE_LFSR_EN to fill the board from an LFSR instead of the fixed i mod 8 pattern.
module game_datapath
    import chicken_pkg::*;
#(
    parameter int BOARD_LEN = 16,
    parameter int TITLE_CYC = 100,
    parameter int SHOW_CYC  = 50,
    parameter int STEP_CYC  = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key,
    input  logic [2:0]  M,
    input  logic        A,
    input  logic        D,
    input  logic        WR,
    output logic        c,
    output logic        go,
    output logic        win,
    output logic [1:0]  cur_player,
    output logic [2:0]  num_players,
    output logic [2:0]  sel_card,
    output logic        prompt,
    output logic [19:0] pos_flat,
    input  logic [4:0]  rd_addr,
    output logic [2:0]  rd_pic
);

    localparam int AW      = $clog2(BOARD_LEN);
    localparam int QUARTER = BOARD_LEN / 4;
    localparam logic [5:0] BL6 = 6'(BOARD_LEN);
    localparam logic [6:0] BL7 = 7'(BOARD_LEN);
    // c is registered, so it is raised from the cycle before the done cycle (cycle counts must be >= 2)
    localparam logic [CNT_W-1:0] TITLE_LAST = CNT_W'(TITLE_CYC - 1);
    localparam logic [CNT_W-1:0] SHUF_LAST  = CNT_W'(BOARD_LEN);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_DONE  = CNT_W'(SHOW_CYC);
    localparam logic [CNT_W-1:0] BL_CNT     = CNT_W'(BOARD_LEN);

    logic [2:0]       m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             win_q, win_d;
    logic [1:0]       cur_q, cur_d;
    logic [2:0]       num_q, num_d;
    logic [2:0]       sel_card_q, sel_card_d;
    logic             sel_valid_q, sel_valid_d;
    logic             prompt_q, prompt_d;
    logic [5:0]       steps_q [MAX_PLAYERS];
    logic [5:0]       steps_d [MAX_PLAYERS];
    logic [2:0]       board_q [BOARD_LEN];
    logic [2:0]       board_d [BOARD_LEN];

    logic             entry;
    logic [CNT_W-1:0] cyc_idx;
    logic [POS_W-1:0] pos_w [MAX_PLAYERS];
    logic [5:0]       target_inc;
    logic [AW-1:0]    target_idx;
    logic [AW-1:0]    wr_idx;
    logic [2:0]       shuffle_pic;

    // cyc_idx is the 1-based cycle number within the current state; it saturates instead of wrapping
    assign entry   = (M != m_q);
    assign cyc_idx = entry ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
    assign wr_idx  = AW'(cyc_idx - 1'b1);

`ifdef SHUFFLE_LFSR_EN
    logic [15:0] lfsr_val;
    logic        lfsr_unused;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_val)
    );

    assign shuffle_pic = lfsr_val[2:0];
    assign lfsr_unused = ^lfsr_val[15:3];
`else
    assign shuffle_pic = cyc_idx[2:0] - 3'd1;
`endif

    generate
        for (genvar gi = 0; gi < MAX_PLAYERS; gi++) begin : g_pos
            logic [6:0] pos_sum;
            assign pos_sum   = 7'(gi * QUARTER) + {1'b0, steps_q[gi]};
            assign pos_w[gi] = POS_W'((pos_sum >= BL7) ? pos_sum - BL7 : pos_sum);
            assign pos_flat[POS_W*gi +: POS_W] = pos_w[gi];
        end
    endgenerate

    assign target_inc = {1'b0, pos_w[cur_q]} + 6'd1;
    assign target_idx = AW'((target_inc == BL6) ? 6'd0 : target_inc);

    always_comb begin
        m_d         = M;
        cnt_d       = cyc_idx;
        win_d       = win_q;
        cur_d       = cur_q;
        num_d       = num_q;
        sel_card_d  = sel_card_q;
        sel_valid_d = sel_valid_q;
        prompt_d    = A;
        steps_d     = steps_q;
        board_d     = board_q;

        if (M == ST_SELECT && WR && key >= 4'd2 && key <= 4'd4) begin
            num_d = key[2:0];
        end

        if (M == ST_WAIT && key != 4'd0) begin
            sel_card_d  = key[2:0] - 3'd1;
            sel_valid_d = (key <= 4'd8);
        end

        if (D && M != ST_WIN && steps_q[cur_q] != BL6) begin
            steps_d[cur_q] = steps_q[cur_q] + 6'd1;
            if (steps_q[cur_q] + 6'd1 == BL6) begin
                win_d = 1'b1;
            end
        end

        if (M == ST_MISS && cyc_idx == SHOW_DONE) begin
            cur_d = ({1'b0, cur_q} + 3'd1 >= num_q) ? 2'd0 : cur_q + 2'd1;
        end

        if (M == ST_SHUFFLE) begin
            if (entry) begin
                for (int p = 0; p < MAX_PLAYERS; p++) begin
                    steps_d[p] = '0;
                end
                cur_d = 2'd0;
                win_d = 1'b0;
            end
            if (cyc_idx <= BL_CNT) begin
                board_d[wr_idx] = shuffle_pic;
            end
        end
    end

    always_comb begin
        c_d = 1'b0;
        case (M)
            ST_TITLE:   c_d = (cyc_idx == TITLE_LAST);
            ST_SHUFFLE: c_d = (cyc_idx == SHUF_LAST);
            ST_MISS:    c_d = (cyc_idx == SHOW_LAST);
            ST_MOVE:    c_d = (cyc_idx == STEP_LAST) && !win_d;
            default:    c_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q         <= ST_TITLE;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            win_q       <= 1'b0;
            cur_q       <= 2'd0;
            num_q       <= 3'd2;
            sel_card_q  <= 3'd0;
            sel_valid_q <= 1'b0;
            prompt_q    <= 1'b0;
            for (int p = 0; p < MAX_PLAYERS; p++) begin
                steps_q[p] <= '0;
            end
            for (int i = 0; i < BOARD_LEN; i++) begin
                board_q[i] <= '0;
            end
        end else begin
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            win_q       <= win_d;
            cur_q       <= cur_d;
            num_q       <= num_d;
            sel_card_q  <= sel_card_d;
            sel_valid_q <= sel_valid_d;
            prompt_q    <= prompt_d;
            steps_q     <= steps_d;
            board_q     <= board_d;
        end
    end

    assign c           = c_q;
    assign win         = win_q;
    assign cur_player  = cur_q;
    assign num_players = num_q;
    assign sel_card    = sel_card_q;
    assign prompt      = prompt_q;
    assign go          = (M == ST_EVAL) && sel_valid_q && (board_q[target_idx] == sel_card_q);
    assign rd_pic      = ({1'b0, rd_addr} < BL6) ? board_q[rd_addr[AW-1:0]] : 3'd0;

endmodule

// File: tb/tb_game_datapath.sv
// Bench for game_datapath: vector tables, hand-written corner sequences and a random game walk
// checked every cycle against a rule-level model of the board, players and state timers.
module tb_game_datapath;
    import chicken_pkg::*;

    localparam int BL = 8;
    localparam int TC = 4;
    localparam int SC = 3;
    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        rst, A, D, WR;
    logic [3:0]  key;
    logic [2:0]  M;
    logic [4:0]  rd_addr;
    logic        c, go, win, prompt;
    logic [1:0]  cur_player;
    logic [2:0]  num_players, sel_card, rd_pic;
    logic [19:0] pos_flat;

    always #5 clk = ~clk;

    game_datapath #(
        .BOARD_LEN (BL),
        .TITLE_CYC (TC),
        .SHOW_CYC  (SC),
        .STEP_CYC  (MC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .M           (M),
        .A           (A),
        .D           (D),
        .WR          (WR),
        .c           (c),
        .go          (go),
        .win         (win),
        .cur_player  (cur_player),
        .num_players (num_players),
        .sel_card    (sel_card),
        .prompt      (prompt),
        .pos_flat    (pos_flat),
        .rd_addr     (rd_addr),
        .rd_pic      (rd_pic)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (game rules, one update per edge) ----------------
    int         m_steps [4];
    int         m_board [BL];
    int         m_cur, m_num, m_sel, m_age_prev;
    bit         m_valid, m_win, m_prompt, model_ok;
    logic [2:0] m_prev;

    function automatic int mpos(input int p);
        return (p * (BL / 4) + m_steps[p]) % BL;
    endfunction

    function automatic int cur_age();
        return (M != m_prev) ? 1 : m_age_prev + 1;
    endfunction

    function automatic bit m_go();
        return (M == ST_EVAL) && m_valid && (m_board[(mpos(m_cur) + 1) % BL] == m_sel);
    endfunction

    function automatic bit m_c(input int age);
        return (M == ST_TITLE && age == TC) || (M == ST_SHUFFLE && age == BL + 1) ||
               (M == ST_MISS && age == SC) || (M == ST_MOVE && age == MC && !m_win);
    endfunction

    function automatic logic [19:0] m_posflat();
        logic [19:0] r;
        r = '0;
        for (int p = 0; p < 4; p++) r[5*p +: 5] = 5'(mpos(p));
        return r;
    endfunction

    function automatic int hit_key();
        return m_board[(mpos(m_cur) + 1) % BL] + 1;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 4; p++) m_steps[p] = 0;
        for (int i = 0; i < BL; i++) m_board[i] = 0;
        m_cur = 0; m_num = 2; m_sel = 0; m_valid = 0; m_win = 0; m_prompt = 0;
        m_prev = ST_TITLE; m_age_prev = 0;
    endtask

    // compare this cycle's outputs with the model, apply the edge to the model, advance one clock
    task automatic tick();
        int age;
        int a;
        age = cur_age();
        if (model_ok) begin
            a = int'(rd_addr);
            chk("model_c",      32'(c),           32'(m_c(age)));
            chk("model_go",     32'(go),          32'(m_go()));
            chk("model_win",    32'(win),         32'(m_win));
            chk("model_cur",    32'(cur_player),  32'(m_cur));
            chk("model_num",    32'(num_players), 32'(m_num));
            chk("model_sel",    32'(sel_card),    32'(m_sel));
            chk("model_prompt", 32'(prompt),      32'(m_prompt));
            chk("model_pos",    32'(pos_flat),    32'(m_posflat()));
            chk("model_rd_pic", 32'(rd_pic),      32'((a < BL) ? m_board[a] : 0));
        end
        if (rst) begin
            model_reset();
            model_ok = 1'b1;
        end else begin
            if (M == ST_SELECT && WR && key >= 2 && key <= 4) m_num = int'(key);
            if (M == ST_WAIT && key != 0) begin
                m_sel   = (int'(key) - 1) % NUM_CARDS;
                m_valid = (key <= 8);
            end
            if (D && M != ST_WIN) begin
                m_steps[m_cur]++;
                if (m_steps[m_cur] == BL) m_win = 1'b1;
            end
            if (M == ST_MISS && age == SC) m_cur = (m_cur + 1) % m_num;
            if (M == ST_SHUFFLE) begin
                if (age == 1) begin
                    for (int p = 0; p < 4; p++) m_steps[p] = 0;
                    m_cur = 0;
                    m_win = 1'b0;
                end
                if (age <= BL) m_board[age-1] = (age - 1) % NUM_CARDS;
            end
            m_prompt   = A;
            m_age_prev = age;
            m_prev     = M;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [2:0] m, input logic [3:0] k, input logic d, input logic wr);
        M       = m;
        key     = k;
        D       = d;
        WR      = wr;
        A       = 1'($urandom_range(0, 1));
        rd_addr = 5'($urandom_range(0, 31));
        #1;
    endtask

    task automatic hold(input logic [2:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            drv(m, 4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)));
            tick();
        end
    endtask

    typedef struct packed {
        logic [3:0] key;
        logic       wr;
        logic [2:0] num;
    } sel_vec_t;

    typedef struct packed {
        logic [3:0] key;
        logic [2:0] sel;
        logic       go;
    } go_vec_t;

    sel_vec_t sel_tab [9];
    go_vec_t  go_tab  [8];

    initial begin : main
        sel_tab[0] = '{4'd3, 1'b1, 3'd3};
        sel_tab[1] = '{4'd7, 1'b1, 3'd3};
        sel_tab[2] = '{4'd4, 1'b0, 3'd3};
        sel_tab[3] = '{4'd4, 1'b1, 3'd4};
        sel_tab[4] = '{4'd1, 1'b1, 3'd4};
        sel_tab[5] = '{4'd5, 1'b1, 3'd4};
        sel_tab[6] = '{4'd0, 1'b1, 3'd4};
        sel_tab[7] = '{4'd2, 1'b1, 3'd2};
        sel_tab[8] = '{4'd3, 1'b1, 3'd3};

        go_tab[0] = '{4'd2,  3'd1, 1'b1};
        go_tab[1] = '{4'd4,  3'd3, 1'b0};
        go_tab[2] = '{4'd12, 3'd3, 1'b0};
        go_tab[3] = '{4'd10, 3'd1, 1'b0};
        go_tab[4] = '{4'd1,  3'd0, 1'b0};
        go_tab[5] = '{4'd8,  3'd7, 1'b0};
        go_tab[6] = '{4'd9,  3'd0, 1'b0};
        go_tab[7] = '{4'd2,  3'd1, 1'b1};

        model_ok = 1'b0;
        model_reset();
        rst = 1'b1; M = ST_TITLE; key = '0; A = 1'b0; D = 1'b0; WR = 1'b0; rd_addr = '0;
        #1;
        tick();
        tick();
        rst = 1'b0;

        // title: c only in cycle 4, reset values before it
        for (int k = 1; k <= 6; k++) begin
            drv(ST_TITLE, 4'd0, 1'b0, 1'b0);
            chk("title_c", 32'(c), 32'(k == TC));
            if (k == 1) chk("reset_prompt", 32'(prompt), 32'd0);
            if (k < TC) begin
                chk("reset_win", 32'(win), 32'd0);
                chk("reset_cur", 32'(cur_player), 32'd0);
                chk("reset_num", 32'(num_players), 32'd2);
                chk("reset_sel", 32'(sel_card), 32'd0);
                chk("reset_go",  32'(go), 32'd0);
                chk("reset_pos", 32'(pos_flat), 32'h31040);  // players at tiles 0,2,4,6
                chk("reset_rd_pic", 32'(rd_pic), 32'd0);
            end
            tick();
        end

        // player-count selection table
        for (int i = 0; i < 9; i++) begin
            drv(ST_SELECT, sel_tab[i].key, 1'b0, sel_tab[i].wr);
            tick();
            chk("select_num", 32'(num_players), 32'(sel_tab[i].num));
        end

        // shuffle: c in cycle 9, board then reads 0..7
        for (int k = 1; k <= 11; k++) begin
            drv(ST_SHUFFLE, 4'd0, 1'b0, 1'b0);
            chk("shuffle_c", 32'(c), 32'(k == BL + 1));
            tick();
        end
        drv(ST_WAIT, 4'd0, 1'b0, 1'b0);
        for (int a = 0; a < 10; a++) begin
            rd_addr = 5'(a);
            #1;
            chk("shuffle_rd_pic", 32'(rd_pic), 32'((a < BL) ? a : 0));
        end
        tick();

        // card selection / match table, player 0 on tile 0 so target tile 1
        for (int i = 0; i < 8; i++) begin
            drv(ST_WAIT, go_tab[i].key, 1'b0, 1'b0);
            chk("wait_go_low", 32'(go), 32'd0);
            tick();
            drv(ST_EVAL, 4'd0, 1'b0, 1'b0);
            chk("eval_sel", 32'(sel_card), 32'(go_tab[i].sel));
            chk("eval_go",  32'(go), 32'(go_tab[i].go));
            tick();
        end

        // three misses with 3 players: turn goes 0->1->2->0
        for (int r = 0; r < 3; r++) begin
            drv(ST_WAIT, 4'd0, 1'b0, 1'b0);
            tick();
            for (int k = 1; k <= SC; k++) begin
                drv(ST_MISS, 4'd0, 1'b0, 1'b0);
                chk("miss_c", 32'(c), 32'(k == SC));
                chk("miss_cur_hold", 32'(cur_player), 32'(r));
                tick();
            end
            drv(ST_WAIT, 4'd0, 1'b0, 1'b0);
            chk("miss_cur_next", 32'(cur_player), 32'((r + 1) % 3));
            tick();
        end

        // player 0 hits eight times; the eighth wins in MOVE cycle 1 and c never fires
        for (int h = 0; h < BL; h++) begin
            drv(ST_WAIT, 4'(((h + 1) % BL) + 1), 1'b0, 1'b0);
            tick();
            drv(ST_EVAL, 4'd0, 1'b1, 1'b0);
            chk("hit_go", 32'(go), 32'd1);
            tick();
            drv(ST_MOVE, 4'd0, 1'b0, 1'b0);
            chk("hit_win", 32'(win), 32'(h == BL - 1));
            chk("hit_pos0", 32'(pos_flat[4:0]), 32'((h + 1) % BL));
            chk("move_c1", 32'(c), 32'd0);
            tick();
            if (h < BL - 1) begin
                drv(ST_MOVE, 4'd0, 1'b0, 1'b0);
                chk("move_c2", 32'(c), 32'd1);
                tick();
            end else begin
                for (int k = 2; k <= 4; k++) begin
                    drv(ST_MOVE, 4'd0, 1'b0, 1'b0);
                    chk("win_move_c", 32'(c), 32'd0);
                    chk("win_sticky", 32'(win), 32'd1);
                    tick();
                end
                rst = 1'b1;
                drv(ST_MOVE, 4'd0, 1'b0, 1'b0);
                tick();
                rst = 1'b0;
                chk("rst_win", 32'(win), 32'd0);
                chk("rst_num", 32'(num_players), 32'd2);
                chk("rst_pos", 32'(pos_flat), 32'h31040);
            end
        end

        // random game walk checked against the model every cycle
        for (int g = 0; g < 4; g++) begin
            hold(ST_TITLE, TC);
            drv(ST_SELECT, 4'($urandom_range(2, 4)), 1'b0, 1'b1);
            tick();
            hold(ST_SELECT, 2);
            hold(ST_SHUFFLE, BL + 1);
            for (int t = 0; t < 200; t++) begin
                int  nw;
                bit  g_ok;
                nw = $urandom_range(1, 3);
                for (int w = 1; w <= nw; w++) begin
                    if (w < nw) drv(ST_WAIT, 4'd0, 1'b0, 1'b0);
                    else if ($urandom_range(0, 1) == 1) drv(ST_WAIT, 4'(hit_key()), 1'b0, 1'b0);
                    else drv(ST_WAIT, 4'($urandom_range(1, 15)), 1'b0, 1'b0);
                    tick();
                end
                drv(ST_EVAL, 4'd0, 1'b0, 1'b0);
                g_ok = m_go();
                D = g_ok;
                #1;
                tick();
                if (g_ok) begin
                    if (m_win) begin
                        hold(ST_MOVE, 1);
                        hold(ST_WIN, 3);
                        break;
                    end
                    hold(ST_MOVE, MC);
                end else begin
                    hold(ST_MISS, SC);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        n_bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/game_datapath.md
# game_datapath

Responder side of the game control FSM: consumes the 3-bit state code `M` and strobes `A`, `D`, `WR`, and returns the `c`, `go` and `win` status bits that drive the FSM's transitions. Owns the board, player positions and turn order, card selection, and all per-state timers. Sits between the FSM and the display/keypad logic in the top level.

## Interface
- `BOARD_LEN`, 16, number of board tiles; multiple of 4, range 8..32
- `TITLE_CYC`, 100, cycles in state 000 before `c`
- `SHOW_CYC`, 50, cycles a missed card stays revealed (state 101)
- `STEP_CYC`, 25, cycles of move animation (state 110)
- `clk` in 1 system clock; single clock domain
- `rst` in 1 reset, synchronous, active-high
- `key` in 4 keypad code; 0 = no key
- `M` in 3 FSM state code
- `A` in 1 FSM awaiting-input strobe
- `D` in 1 FSM advance strobe (state 100 and `go`)
- `WR` in 1 FSM config-write enable
- `c` out 1 state-done pulse, registered
- `go` out 1 selected card matches target tile; combinational from registers
- `win` out 1 current player finished a lap, registered, sticky
- `cur_player` out 2 whose turn, 0..num_players-1
- `num_players` out 3 latched player count, 2..4
- `sel_card` out 3 last selected card
- `prompt` out 1 equals registered `A`, for display blink
- `pos_flat` out 4*5 player positions, player p at bits [5p+4:5p]
- `rd_addr` in 5 display read address into board
- `rd_pic` out 3 picture on tile `rd_addr`; 0 if out of range

## Operation
- State codes: 000 TITLE, 001 SELECT, 010 SHUFFLE, 011 WAIT, 100 EVAL, 101 MISS, 110 MOVE, 111 WIN.
- State entry is detected by comparing `M` with a registered copy `m_q`; the entry cycle is cycle 1 of the state.
- Per-state counter: cleared on entry. `c` is high for exactly one cycle, in cycle N of the state, then stays low until the next entry:
  - TITLE: N=TITLE_CYC
  - SHUFFLE: N=BOARD_LEN+1
  - MISS: N=SHOW_CYC
  - MOVE: N=STEP_CYC, suppressed while `win`=1
  - All other states: `c`=0.
- SELECT: on each edge with `WR`=1, `M`=001 and `key` in 2..4, `num_players` <= `key[2:0]`. Other keys are ignored.
- SHUFFLE, cycle 1: all step counters <= 0, `cur_player` <= 0, `win` <= 0.
- SHUFFLE, cycles 1..BOARD_LEN: write tile (cycle-1) with its picture.
- Player p start tile = p*(BOARD_LEN/4). Position = (start + steps) mod BOARD_LEN.
- WAIT: on an edge with `M`=011 and `key`!=0:
  - `sel_card` <= `key`-1.
  - `sel_valid` <= (`key` <= 8).
- Card i shows picture i.
- EVAL: target = (position of `cur_player` + 1) mod BOARD_LEN. `go` = `sel_valid` AND tile[target]==`sel_card`. `go`=0 in every other state.
- Edge with `D`=1:
  - steps[cur_player]++.
  - If the new steps == BOARD_LEN, set `win`. It holds until SHUFFLE entry or `rst`.
- MISS: on the `c` cycle, `cur_player` <= (cur_player+1) mod num_players. A correct guess keeps the turn.
- WIN: everything frozen; `c`=0.

## Timing
- Reset values:
  - `c`=0, `win`=0, `cur_player`=0, `num_players`=2, `sel_card`=0, `sel_valid`=0.
  - All steps 0, all board tiles 0, `m_q`=000.
  - `prompt`=0. LFSR seed 16'hACE1.
- `go` is valid in the first cycle of EVAL, so the FSM can sample it on the next edge.
- `win` is set on the `D` edge, so it is already 1 in MOVE cycle 1. The FSM therefore goes straight to WIN and `c` never fires.
- Reset mid-state takes effect on the next edge and overrides every other update.
- The counter does not restart while `M` is unchanged.
- Position arithmetic wraps modulo BOARD_LEN. `rd_pic` has zero read latency.

## Configuration
- `SHUFFLE_LFSR_EN` defined: tile picture = `lfsr[2:0]` of a free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), advanced every cycle from reset.
- `SHUFFLE_LFSR_EN` undefined: tile i picture = i mod 8, deterministic.
- In both cases SHUFFLE timing and the `c` position are identical.

## Structure
- Package `chicken_pkg`: the eight 3-bit state-code localparams, `NUM_CARDS`=8, and the max player count of 4.
- One sub-module `lfsr16` (clk, rst, q[15:0]). It is instantiated only under `SHUFFLE_LFSR_EN`.

## Test plan
All tests use BOARD_LEN=8, TITLE_CYC=4, SHOW_CYC=3, STEP_CYC=2 and macro undefined unless noted.
- Reset, then hold M=000 → `c` high only in cycle 4; all outputs at their reset values beforehand.
- M=001, WR=1, key=3, then key=7 → `num_players`=3 and it stays 3.
- M=010 for 9 cycles → `c` in cycle 9; `rd_pic` for addr 0..7 = 0..7.
- Player 0 at position 0, M=011 key=2 then M=100 → `go`=1. With key=4, `go`=0. With key=12, `go`=0.
- MISS with num_players=3, cur_player=2 → `cur_player`=0 after the `c` cycle at cycle 3.
- steps[0]=7 plus one `D` pulse → `win`=1 in MOVE cycle 1; `c` never asserts; `rst` mid-MOVE clears `win` next edge.
